// File: rtl/regfile_read_stage.sv
// Read-port front end for the tristate-cell register file array.
// Decodes two source addresses into one-hot word lines, samples the array
// bitlines with write-back bypass, and presents the operands to execute
// through a valid/ready output register backed by a one-entry skid buffer.
// Held operands (output and skid) snoop the write port so they never go stale.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid / in_ready       request handshake from decode
//   rs1_addr, rs2_addr        source addresses
//   ReadEnable1/2             one-hot word lines to the array read ports
//   Bitline1/2                array read-port data
//   wr_en, wr_addr, wr_data   write-back port (same strobe the array uses)
//   out_valid / out_ready     operand handshake toward execute
//   rs1_data, rs2_data        registered operands
module regfile_read_stage #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [NUM_REGS-1:0]   ReadEnable1,
    output logic [NUM_REGS-1:0]   ReadEnable2,
    input  logic [DATA_WIDTH-1:0] Bitline1,
    input  logic [DATA_WIDTH-1:0] Bitline2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data
);

    // Hardwired-zero register check.
    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Replace a held operand with write-back data when its address is written.
    function automatic logic [DATA_WIDTH-1:0] snoop(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] d,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0] wd
    );
        if (we && !is_zero(a) && (wa == a)) return wd;
        return d;
    endfunction

    // Fresh operand: zero register, then bypass (array still shows old Q), then bitline.
    function automatic logic [DATA_WIDTH-1:0] op_sel(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] bl,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0] wd
    );
        if (is_zero(a)) return '0;
        return snoop(a, bl, we, wa, wd);
    endfunction

    logic                  out_valid_q, out_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [ADDR_WIDTH-1:0] out_a1_q, out_a1_d, out_a2_q, out_a2_d;
    logic [DATA_WIDTH-1:0] out_d1_q, out_d1_d, out_d2_q, out_d2_d;
    logic [ADDR_WIDTH-1:0] skid_a1_q, skid_a1_d, skid_a2_q, skid_a2_d;
    logic [DATA_WIDTH-1:0] skid_d1_q, skid_d1_d, skid_d2_q, skid_d2_d;

    logic                  accept_c;
    logic [DATA_WIDTH-1:0] new_d1_c, new_d2_c;

    // in_ready comes straight from the skid flop: no path from out_ready.
    assign in_ready  = ~skid_valid_q;
    // Gated by rst so no word line fires while the stage is held in reset.
    assign accept_c  = in_valid & ~skid_valid_q & rst;

    assign out_valid = out_valid_q;
    assign rs1_data  = out_d1_q;
    assign rs2_data  = out_d2_q;

    // Word lines enabled only in an accepting cycle; undriven bitlines are never used.
    always_comb begin
        ReadEnable1 = '0;
        ReadEnable2 = '0;
        if (accept_c) begin
            ReadEnable1 = NUM_REGS'(1) << rs1_addr;
            ReadEnable2 = NUM_REGS'(1) << rs2_addr;
        end
    end

    always_comb begin
        new_d1_c = op_sel(rs1_addr, Bitline1, wr_en, wr_addr, wr_data);
        new_d2_c = op_sel(rs2_addr, Bitline2, wr_en, wr_addr, wr_data);
    end

    // Next state: held entries snoop by default, then handshake moves.
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_a1_d     = out_a1_q;
        out_a2_d     = out_a2_q;
        out_d1_d     = snoop(out_a1_q, out_d1_q, wr_en, wr_addr, wr_data);
        out_d2_d     = snoop(out_a2_q, out_d2_q, wr_en, wr_addr, wr_data);
        skid_a1_d    = skid_a1_q;
        skid_a2_d    = skid_a2_q;
        skid_d1_d    = snoop(skid_a1_q, skid_d1_q, wr_en, wr_addr, wr_data);
        skid_d2_d    = snoop(skid_a2_q, skid_d2_q, wr_en, wr_addr, wr_data);

        if (out_valid_q && out_ready) begin
            if (skid_valid_q) begin
                // Skid drains into the output; accept is impossible here.
                out_a1_d     = skid_a1_q;
                out_a2_d     = skid_a2_q;
                out_d1_d     = skid_d1_d;
                out_d2_d     = skid_d2_d;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                out_a1_d = rs1_addr;
                out_a2_d = rs2_addr;
                out_d1_d = new_d1_c;
                out_d2_d = new_d2_c;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!out_valid_q) begin
            if (accept_c) begin
                out_valid_d = 1'b1;
                out_a1_d    = rs1_addr;
                out_a2_d    = rs2_addr;
                out_d1_d    = new_d1_c;
                out_d2_d    = new_d2_c;
            end
        end else if (accept_c) begin
            // Output stalled: park the new request in the skid buffer.
            skid_valid_d = 1'b1;
            skid_a1_d    = rs1_addr;
            skid_a2_d    = rs2_addr;
            skid_d1_d    = new_d1_c;
            skid_d2_d    = new_d2_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_a1_q     <= '0;
            out_a2_q     <= '0;
            out_d1_q     <= '0;
            out_d2_q     <= '0;
            skid_a1_q    <= '0;
            skid_a2_q    <= '0;
            skid_d1_q    <= '0;
            skid_d2_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_a1_q     <= out_a1_d;
            out_a2_q     <= out_a2_d;
            out_d1_q     <= out_d1_d;
            out_d2_q     <= out_d2_d;
            skid_a1_q    <= skid_a1_d;
            skid_a2_q    <= skid_a2_d;
            skid_d1_q    <= skid_d1_d;
            skid_d2_q    <= skid_d2_d;
        end
    end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Scoreboard bench for regfile_read_stage: accepted requests are pushed with
// their expected operands, held entries are updated on write-back, and the
// head entry is compared while the DUT presents it.
module tb_regfile_read_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned NR = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [AW-1:0] rs1_addr, rs2_addr;
    logic [NR-1:0] ReadEnable1, ReadEnable2;
    logic [DW-1:0] Bitline1, Bitline2;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] rs1_data, rs2_data;

    regfile_read_stage #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
        .Bitline1(Bitline1), .Bitline2(Bitline2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } entry_t;

    entry_t sb_q[$];
    int     n_vec = 0;
    int     n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_op(input logic [AW-1:0] a, input logic [DW-1:0] bl);
        if (a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return bl;
    endfunction

    // One clock: drive at negedge, check mid-cycle, advance the model, take the edge.
    task automatic step(input logic iv, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic [DW-1:0] b1, input logic [DW-1:0] b2,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic ordy);
        logic          acc;
        logic [NR-1:0] oh1, oh2;
        entry_t        e;
        @(negedge clk);
        in_valid = iv; rs1_addr = r1; rs2_addr = r2; Bitline1 = b1; Bitline2 = b2;
        wr_en = we; wr_addr = wa; wr_data = wd; out_ready = ordy;
        #1;
        acc = iv && (sb_q.size() < 2);
        oh1 = '0; oh2 = '0;
        if (acc) begin
            oh1[r1] = 1'b1;
            oh2[r2] = 1'b1;
        end
        chk("in_ready", 32'(in_ready), 32'(sb_q.size() < 2));
        chk("re1", 32'(ReadEnable1), 32'(oh1));
        chk("re2", 32'(ReadEnable2), 32'(oh2));
        chk("out_valid", 32'(out_valid), 32'(sb_q.size() > 0));
        if (sb_q.size() > 0) begin
            chk("rs1_data", 32'(rs1_data), 32'(sb_q[0].d1));
            chk("rs2_data", 32'(rs2_data), 32'(sb_q[0].d2));
        end
        if (sb_q.size() > 0 && ordy) void'(sb_q.pop_front());
        foreach (sb_q[i]) begin
            if (we && wa != 0 && sb_q[i].a1 == wa) sb_q[i].d1 = wd;
            if (we && wa != 0 && sb_q[i].a2 == wa) sb_q[i].d2 = wd;
        end
        if (acc) begin
            e.a1 = r1; e.a2 = r2;
            e.d1 = exp_op(r1, b1);
            e.d2 = exp_op(r2, b2);
            sb_q.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 3'd0, 16'hDEAD, 16'hBEEF, 1'b0, 3'd0, 16'h0, ordy);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; rs1_addr = 3'd3; rs2_addr = 3'd5;
        Bitline1 = 16'h1234; Bitline2 = 16'hABCD;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;

        // Reset with a request pending: nothing enabled, nothing emitted.
        #2;
        chk("rst_re1", 32'(ReadEnable1), 32'h0);
        chk("rst_re2", 32'(ReadEnable2), 32'h0);
        chk("rst_ov", 32'(out_valid), 32'h0);
        chk("rst_rs1", 32'(rs1_data), 32'h0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;

        // Plain read.
        step(1'b1, 3'd3, 3'd5, 16'h1234, 16'hABCD, 1'b0, 3'd0, 16'h0, 1'b1);
        // Same-cycle bypass on rs1.
        step(1'b1, 3'd3, 3'd5, 16'h1234, 16'hABCD, 1'b1, 3'd3, 16'h00FF, 1'b1);
        // Zero register ignores bitline and write-back.
        step(1'b1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b1, 3'd0, 16'h7777, 1'b1);
        // Equal source addresses.
        step(1'b1, 3'd6, 3'd6, 16'h4242, 16'h4242, 1'b0, 3'd0, 16'h0, 1'b1);
        idle(1'b1);

        // Back-to-back under stall: second goes to skid, third is refused.
        step(1'b1, 3'd1, 3'd2, 16'h1111, 16'h2222, 1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b1, 3'd4, 3'd7, 16'h4444, 16'h7777, 1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b1, 3'd3, 3'd3, 16'h3333, 16'h3333, 1'b0, 3'd0, 16'h0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Snoop a stalled rs2.
        step(1'b1, 3'd2, 3'd5, 16'h0202, 16'h0505, 1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 1'b1, 3'd5, 16'h5A5A, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Reset mid-stall discards both entries.
        step(1'b1, 3'd1, 3'd1, 16'hAAAA, 16'hAAAA, 1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b1, 3'd2, 3'd2, 16'hBBBB, 16'hBBBB, 1'b0, 3'd0, 16'h0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ov", 32'(out_valid), 32'h0);
        chk("mid_rst_re1", 32'(ReadEnable1), 32'h0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        idle(1'b1);
        idle(1'b1);

        // Random traffic with write-back and back-pressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom),
                 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 2) == 0), 3'($urandom), 16'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
